ql_video_fetch: RTL and testbench

Video word prefetcher between the SDRAM arbiter and the ZX8301 display ULA. At each line start it fetches one display line of 16-bit screen words (64 words = 512 px in mode 4, or 256 px in mode 8) from a given word address. It buffers the words in a small FIFO and hands one word to the ULA per read strobe. When the line is complete it releases the bus to the microdrive emulation through mdv_men.

---
 rtl/ql_video_fetch_if.sv | 13 +
 rtl/ql_video_fetch.sv | 137 +++++++++++++
 tb/tb_ql_video_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ql_video_fetch_if.sv
// SDRAM read port between the video fetcher (master) and the arbiter (slave).
// One outstanding request; mem_ack retires it and qualifies mem_data.
interface ql_video_fetch_if #(
  parameter int AW = 19
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_data);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/ql_video_fetch.sv
// Per-line screen word prefetcher: fetches LINE_WORDS words from SDRAM into a
// small FIFO and serves them to the ULA, releasing the bus (mdv_men) when done.
module ql_video_fetch #(
  parameter int DEPTH      = 8,
  parameter int LINE_WORDS = 64,
  parameter int AW         = 19
) (
  input  logic              clk_video,
  input  logic              reset,
  input  logic              line_start,
  input  logic [AW-1:0]     line_addr,
  input  logic              fetch_en,
  input  logic              word_rd,
  output logic [15:0]       word,
  output logic              word_valid,
  output logic              underrun,
  output logic              mdv_men,
  ql_video_fetch_if.master  mem
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [FW-1:0] fetched;
    logic          req;
    logic [AW-1:0] maddr;
  } fetch_t;

  state_t        state, state_nxt;
  fetch_t        cur, nxt;
  logic [FW-1:0] fetched_inc;

  logic [15:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, flush;

  assign mem.mem_req  = cur.req;
  assign mem.mem_addr = cur.maddr;
  assign fetched_inc  = cur.fetched + FW'(1);

  // Fetch control; line_start overrides every state and drops a coincident ack.
  always_comb begin
    nxt       = cur;
    state_nxt = state;
    push      = 1'b0;
    flush     = 1'b0;
    if (line_start) begin
      flush       = 1'b1;
      nxt.addr    = line_addr;
      nxt.fetched = '0;
      nxt.req     = 1'b0;
      state_nxt   = fetch_en ? FETCH : IDLE;
    end else begin
      unique case (state)
        FETCH: begin
          if (count < (PW+1)'(DEPTH)) begin
            nxt.req   = 1'b1;
            nxt.maddr = cur.addr;
            state_nxt = WAIT;
          end else begin
            nxt.req = 1'b0;
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            push        = 1'b1;
            nxt.req     = 1'b0;
            nxt.addr    = cur.addr + AW'(1);
            nxt.fetched = fetched_inc;
            state_nxt   = (fetched_inc == FW'(LINE_WORDS)) ? DONE : FETCH;
          end
        end
        default: nxt.req = 1'b0;
      endcase
    end
  end

  // A read strobe alongside line_start is served as an underrun.
  always_comb begin
    pop = word_rd && !line_start && (count != '0);
  end

  always_ff @(posedge clk_video) begin
    if (reset) begin
      state   <= IDLE;
      cur     <= '0;
      mdv_men <= 1'b1;
    end else begin
      state   <= state_nxt;
      cur     <= nxt;
      mdv_men <= (state_nxt == IDLE) || (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk_video) begin
    if (push) fifo_mem[wr_ptr] <= mem.mem_data;
  end

  always_ff @(posedge clk_video) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pop reads the pre-push head, so a word pushed this cycle is not yet visible.
  always_ff @(posedge clk_video) begin
    if (reset) begin
      word       <= '0;
      word_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      word_valid <= word_rd;
      if (word_rd) begin
        if (pop) begin
          word <= fifo_mem[rd_ptr];
        end else begin
          word     <= '0;
          underrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ql_video_fetch.sv
// Directed bench for ql_video_fetch: main instance (64-word lines) plus a
// 4-word-line instance for the address wrap case.
module tb_ql_video_fetch;
  logic        clk_video = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [18:0] line_addr = '0;
  logic        fetch_en = 1'b0;
  logic        word_rd;
  logic [15:0] word;
  logic        word_valid, underrun, mdv_men;

  logic        ls4 = 1'b0;
  logic [18:0] la4 = '0;
  logic        fe4 = 1'b0;
  logic [15:0] word4;
  logic        wv4, ur4, mdv4;

  logic        man_rd = 1'b0, auto_rd = 1'b0;
  logic        man_ack = 1'b0, a_ack = 1'b0, a_ack4 = 1'b0;
  logic [15:0] man_data = '0, a_data = '0, a_data4 = '0;
  logic        auto_ack = 1'b0;
  int          ack_lat = 0, wcnt = 0;
  logic        pop_go = 1'b0;
  int          pop_target = 0, pop_period = 8, popped = 0, pcnt = 0;

  logic [18:0] ackq[$];
  logic [18:0] aq4[$];
  logic [15:0] wq[$];

  int n_chk = 0, n_fail = 0;

  ql_video_fetch_if #(.AW(19)) mem  ();
  ql_video_fetch_if #(.AW(19)) mem4 ();

  assign word_rd       = man_rd | auto_rd;
  assign mem.mem_ack   = a_ack | man_ack;
  assign mem.mem_data  = man_ack ? man_data : a_data;
  assign mem4.mem_ack  = a_ack4;
  assign mem4.mem_data = a_data4;

  ql_video_fetch #(.DEPTH(8), .LINE_WORDS(64), .AW(19)) u_dut (
    .clk_video (clk_video), .reset (reset), .line_start (line_start),
    .line_addr (line_addr), .fetch_en (fetch_en), .word_rd (word_rd),
    .word (word), .word_valid (word_valid), .underrun (underrun),
    .mdv_men (mdv_men), .mem (mem.master)
  );

  ql_video_fetch #(.DEPTH(8), .LINE_WORDS(4), .AW(19)) u_dut4 (
    .clk_video (clk_video), .reset (reset), .line_start (ls4),
    .line_addr (la4), .fetch_en (fe4), .word_rd (1'b0),
    .word (word4), .word_valid (wv4), .underrun (ur4),
    .mdv_men (mdv4), .mem (mem4.master)
  );

  always #5 clk_video = ~clk_video;

  // Memory model: acks ack_lat negedges after mem_req is seen, data = addr[15:0].
  always @(negedge clk_video) begin
    a_ack = 1'b0;
    if (auto_ack && mem.mem_req) begin
      if (wcnt >= ack_lat) begin
        a_ack  = 1'b1;
        a_data = mem.mem_addr[15:0];
        ackq.push_back(mem.mem_addr);
        wcnt   = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk_video) begin
    a_ack4 = 1'b0;
    if (mem4.mem_req) begin
      a_ack4  = 1'b1;
      a_data4 = mem4.mem_addr[15:0];
      aq4.push_back(mem4.mem_addr);
    end
  end

  always @(negedge clk_video) begin
    auto_rd = 1'b0;
    if (!pop_go) begin
      popped = 0;
      pcnt   = 0;
    end else if (popped < pop_target) begin
      if (pcnt >= pop_period - 1) begin
        auto_rd = 1'b1;
        pcnt    = 0;
        popped++;
      end else begin
        pcnt++;
      end
    end
  end

  always @(negedge clk_video) begin
    if (word_valid) wq.push_back(word);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_video);
  endtask

  task automatic start_line(input logic [18:0] a, input logic fe);
    @(negedge clk_video);
    line_start = 1'b1; line_addr = a; fetch_en = fe;
    @(negedge clk_video);
    line_start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_word"},    32'(word), 32'h0);
    chk({tag, "_valid"},   32'(word_valid), 32'h0);
    chk({tag, "_underrun"},32'(underrun), 32'h0);
    chk({tag, "_req"},     32'(mem.mem_req), 32'h0);
    chk({tag, "_addr"},    32'(mem.mem_addr), 32'h0);
    chk({tag, "_mdv"},     32'(mdv_men), 32'h1);
  endtask

  initial begin
    int a_base, w_base, i;
    logic ok;

    step(3);
    reset = 1'b0;
    step(1);
    chk_reset_state("rst");

    // Line of 64 words, 2-cycle ack latency, paced pops.
    auto_ack = 1'b1; ack_lat = 2;
    a_base = ackq.size(); w_base = wq.size();
    start_line(19'h10000, 1'b1);
    chk("t1_mdv_busy", 32'(mdv_men), 32'h0);
    chk("t1_req_first", 32'(mem.mem_req), 32'h0);
    step(1);
    chk("t1_req_up", 32'(mem.mem_req), 32'h1);
    chk("t1_addr0", 32'(mem.mem_addr), 32'h10000);
    step(14);
    pop_target = 64; pop_period = 4; pop_go = 1'b1;
    for (i = 0; i < 3000 && !(mdv_men && popped == 64); i++) step(1);
    step(3);
    pop_go = 1'b0;
    chk("t1_done", 32'(mdv_men && popped == 64), 32'h1);
    chk("t1_acks", 32'(ackq.size() - a_base), 32'd64);
    ok = (ackq.size() - a_base) == 64;
    for (int k = 0; ok && k < 64; k++) ok = (ackq[a_base+k] == 19'h10000 + 19'(k));
    chk("t1_addr_seq", 32'(ok), 32'h1);
    chk("t1_last_addr", 32'(mem.mem_addr), 32'h1003F);
    chk("t1_req_idle", 32'(mem.mem_req), 32'h0);
    chk("t1_words", 32'(wq.size() - w_base), 32'd64);
    chk("t1_underrun", 32'(underrun), 32'h0);

    // Zero-wait memory, no pops: fill stops at DEPTH, one pop buys one request.
    ack_lat = 0;
    a_base = ackq.size(); w_base = wq.size();
    start_line(19'h00100, 1'b1);
    step(40);
    chk("t2_fill8", 32'(ackq.size() - a_base), 32'd8);
    chk("t2_req_stalled", 32'(mem.mem_req), 32'h0);
    chk("t2_mdv", 32'(mdv_men), 32'h0);
    man_rd = 1'b1; step(1); man_rd = 1'b0;
    step(10);
    chk("t2_one_more", 32'(ackq.size() - a_base), 32'd9);
    chk("t2_pop_cnt", 32'(wq.size() - w_base), 32'd1);
    if (wq.size() > w_base) chk("t2_pop_word", 32'(wq[w_base]), 32'h0100);
    chk("t2_last_addr", 32'(mem.mem_addr), 32'h00108);

    // Pop every 8 cycles with always-ready memory: data in address order.
    a_base = ackq.size(); w_base = wq.size();
    start_line(19'h32000, 1'b1);
    pop_target = 64; pop_period = 8; pop_go = 1'b1;
    for (i = 0; i < 1000 && popped != 64; i++) step(1);
    step(3);
    pop_go = 1'b0;
    chk("t3_popped", 32'(popped), 32'd64);
    chk("t3_words", 32'(wq.size() - w_base), 32'd64);
    ok = (wq.size() - w_base) == 64;
    for (int k = 0; ok && k < 64; k++) ok = (wq[w_base+k] == 16'h2000 + 16'(k));
    chk("t3_data_seq", 32'(ok), 32'h1);
    chk("t3_acks", 32'(ackq.size() - a_base), 32'd64);
    chk("t3_underrun", 32'(underrun), 32'h0);
    chk("t3_mdv_done", 32'(mdv_men), 32'h1);

    // line_start during WAIT with a coincident ack: ack dropped, FIFO flushed.
    auto_ack = 1'b0;
    start_line(19'h04000, 1'b1);
    step(1);
    chk("t5_req", 32'(mem.mem_req), 32'h1);
    chk("t5_addr", 32'(mem.mem_addr), 32'h04000);
    step(2);
    chk("t5_req_hold", 32'(mem.mem_req), 32'h1);
    chk("t5_addr_hold", 32'(mem.mem_addr), 32'h04000);
    line_start = 1'b1; line_addr = 19'h05000; fetch_en = 1'b1;
    man_ack = 1'b1; man_data = 16'hBEEF;
    step(1);
    line_start = 1'b0; man_ack = 1'b0;
    chk("t5_req_drop", 32'(mem.mem_req), 32'h0);
    step(1);
    chk("t5_req_new", 32'(mem.mem_req), 32'h1);
    chk("t5_addr_new", 32'(mem.mem_addr), 32'h05000);
    man_ack = 1'b1; man_data = 16'h1234;
    step(1);
    man_ack = 1'b0; man_rd = 1'b1;
    step(1);
    man_rd = 1'b0;
    chk("t5_pop_valid", 32'(word_valid), 32'h1);
    chk("t5_pop_word", 32'(word), 32'h1234);
    step(1);
    chk("t5_valid_low", 32'(word_valid), 32'h0);
    chk("t5_word_hold", 32'(word), 32'h1234);
    chk("t5_next_addr", 32'(mem.mem_addr), 32'h05001);
    chk("t5_underrun", 32'(underrun), 32'h0);

    // fetch_en=0 on line_start: no request, bus released.
    start_line(19'h06000, 1'b0);
    chk("t6_mdv", 32'(mdv_men), 32'h1);
    chk("t6_req", 32'(mem.mem_req), 32'h0);
    step(4);
    chk("t6_req_idle", 32'(mem.mem_req), 32'h0);

    // Underrun after reset, sticky across line_start (which itself pops nothing).
    reset = 1'b1; step(2); reset = 1'b0; step(1);
    chk_reset_state("rst2");
    man_rd = 1'b1; step(1); man_rd = 1'b0;
    chk("t4_valid", 32'(word_valid), 32'h1);
    chk("t4_word", 32'(word), 32'h0);
    chk("t4_underrun", 32'(underrun), 32'h1);
    step(1);
    chk("t4_valid_low", 32'(word_valid), 32'h0);
    line_start = 1'b1; line_addr = 19'h00200; fetch_en = 1'b1; man_rd = 1'b1;
    step(1);
    line_start = 1'b0; man_rd = 1'b0;
    chk("t4_ls_valid", 32'(word_valid), 32'h1);
    chk("t4_ls_word", 32'(word), 32'h0);
    chk("t4_sticky", 32'(underrun), 32'h1);

    // 4-word line starting two below the top of the address space.
    @(negedge clk_video); ls4 = 1'b1; la4 = 19'h7FFFE; fe4 = 1'b1;
    @(negedge clk_video); ls4 = 1'b0;
    for (i = 0; i < 100 && !mdv4; i++) step(1);
    step(4);
    chk("w_acks", 32'(aq4.size()), 32'd4);
    if (aq4.size() == 4) begin
      chk("w_a0", 32'(aq4[0]), 32'h7FFFE);
      chk("w_a1", 32'(aq4[1]), 32'h7FFFF);
      chk("w_a2", 32'(aq4[2]), 32'h00000);
      chk("w_a3", 32'(aq4[3]), 32'h00001);
    end
    chk("w_mdv", 32'(mdv4), 32'h1);
    chk("w_req", 32'(mem4.mem_req), 32'h0);
    @(negedge clk_video); ls4 = 1'b1; fe4 = 1'b0;
    @(negedge clk_video); ls4 = 1'b0;
    step(4);
    chk("w_fe0_acks", 32'(aq4.size()), 32'd4);
    chk("w_fe0_mdv", 32'(mdv4), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
